// File: rtl/nes_bus_pkg.sv
// Shared NES system-bus constants and the OAM DMA state encoding.
package nes_bus_pkg;

  localparam logic [15:0] PPU_OAMDATA_ADDR = 16'h2004;
  localparam logic [15:0] OAM_DMA_REG_ADDR = 16'h4014;
  localparam int unsigned OAM_DMA_XFER_LEN = 256;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_master.sv
// OAM DMA bus master: a $4014 write halts the CPU and copies {page,00..FF} into $2004.
// Define OAM_DMA_ODD_ALIGN_EN for the extra alignment cycle when the halt lands on an odd cycle.
module oam_dma_master
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = OAM_DMA_REG_ADDR,
  parameter logic [15:0] OAMDATA_ADDR = PPU_OAMDATA_ADDR,
  parameter int unsigned XFER_LEN     = OAM_DMA_XFER_LEN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rwe,
  input  logic [7:0]  bus_rdata,
  output logic        cpu_halt,
  output logic        dma_active,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rwe,
  output logic        done_pulse
);

  localparam logic [7:0] LastIdx = 8'(XFER_LEN - 1);

  oam_dma_state_t state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic        halt_q, halt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rwe_q, rwe_d;
  logic        done_q, done_d;

`ifdef OAM_DMA_ODD_ALIGN_EN
  // 0 on even CPU cycles counted from reset.
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (cpu_ce) begin
      parity_q <= ~parity_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      halt_q  <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      rwe_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      halt_q  <= halt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rwe_q   <= rwe_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    halt_d  = halt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rwe_d   = rwe_q;
    done_d  = 1'b0;
    if (cpu_ce) begin
      unique case (state_q)
        IDLE: begin
          if (cpu_rwe && (cpu_addr == DMA_REG_ADDR)) begin
            page_d  = cpu_wdata;
            idx_d   = 8'h00;
            halt_d  = 1'b1;
            state_d = HALT;
          end
        end
        HALT: begin
          state_d = READ;
          addr_d  = {page_q, idx_q};
          rwe_d   = 1'b0;
`ifdef OAM_DMA_ODD_ALIGN_EN
          if (parity_q) begin
            state_d = ALIGN;
            addr_d  = 16'h0000;
          end
`endif
        end
        ALIGN: begin
          state_d = READ;
          addr_d  = {page_q, idx_q};
          rwe_d   = 1'b0;
        end
        READ: begin
          state_d = WRITE;
          addr_d  = OAMDATA_ADDR;
          wdata_d = bus_rdata;
          rwe_d   = 1'b1;
        end
        WRITE: begin
          // idx wraps within 8 bits; the page byte is never carried into.
          idx_d = idx_q + 8'd1;
          if (idx_q == LastIdx) begin
            state_d = IDLE;
            halt_d  = 1'b0;
            addr_d  = 16'h0000;
            wdata_d = 8'h00;
            rwe_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
            addr_d  = {page_q, idx_d};
            rwe_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cpu_halt   = halt_q;
  assign dma_active = (state_q != IDLE);
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_rwe    = rwe_q;
  assign done_pulse = done_q;

endmodule

// File: tb/tb_oam_dma_master.sv
// Self-checking bench for oam_dma_master: table of transfers plus reset/ignore/spacing sequences.
`timescale 1ns/1ps
module tb_oam_dma_master;

`ifdef OAM_DMA_ODD_ALIGN_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rwe;
  logic [7:0]  bus_rdata;
  logic        cpu_halt;
  logic        dma_active;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rwe;
  logic        done_pulse;

  always #5 clk = ~clk;

  oam_dma_master dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_ce     (cpu_ce),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rwe    (cpu_rwe),
    .bus_rdata  (bus_rdata),
    .cpu_halt   (cpu_halt),
    .dma_active (dma_active),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rwe    (bus_rwe),
    .done_pulse (done_pulse)
  );

  // Memory model: page $02 holds i at offset i.
  function automatic logic [7:0] ram(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h02;
  endfunction

  assign bus_rdata = ram(bus_addr);

  typedef struct {
    logic [7:0]  page;
    int          gap;
    int          pre;
    logic [15:0] first_rd;
    logic [15:0] last_rd;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_data[$];
  logic [15:0] exp_rd[$];
  int          strobe_cnt, halted_cnt, done_cnt, wr_cnt;
  logic [15:0] last_addr, first_rd_seen, last_rd_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One CPU cycle strobe, spacing gap clocks; monitors the DUT around it.
  task automatic strobe(input logic [15:0] a, input logic [7:0] d, input logic w,
                        input int gap);
    logic [26:0] snap;
    @(negedge clk);
    if (cpu_halt) halted_cnt++;
    if (cpu_halt && bus_rwe) begin
      wr_cnt++;
      check("wr_addr", 32'(bus_addr), 32'h2004);
      if (exp_data.size() == 0 || exp_rd.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        check("wr_data", 32'(bus_wdata), 32'(exp_data.pop_front()));
        check("rd_addr", 32'(last_addr), 32'(exp_rd.pop_front()));
      end
      if (wr_cnt == 1) first_rd_seen = last_addr;
      last_rd_seen = last_addr;
    end
    last_addr = bus_addr;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_rwe   = w;
    cpu_ce    = 1'b1;
    @(negedge clk);
    cpu_ce = 1'b0;
    strobe_cnt++;
    if (done_pulse) done_cnt++;
    snap = {cpu_halt, dma_active, bus_rwe, bus_addr, bus_wdata};
    for (int i = 2; i < gap; i++) begin
      @(negedge clk);
      if (done_pulse) done_cnt++;
      check("hold", 32'({cpu_halt, dma_active, bus_rwe, bus_addr, bus_wdata}), 32'(snap));
    end
  endtask

  task automatic start_dma(input logic [7:0] page, input int gap, output int exp_len);
    exp_len = 513 + ((AlignEn && (((strobe_cnt + 1) % 2) == 1)) ? 1 : 0);
    exp_data.delete();
    exp_rd.delete();
    for (int i = 0; i < 256; i++) begin
      exp_data.push_back(ram({page, 8'(i)}));
      exp_rd.push_back({page, 8'(i)});
    end
    halted_cnt = 0;
    done_cnt   = 0;
    wr_cnt     = 0;
    strobe(16'h4014, page, 1'b1, gap);
  endtask

  task automatic run_row(input vec_t v);
    int exp_len;
    for (int i = 0; i < v.pre; i++) strobe(16'h0000, 8'h00, 1'b0, v.gap);
    start_dma(v.page, v.gap, exp_len);
    check("halt_after_trigger", 32'(cpu_halt), 32'd1);
    check("active_after_trigger", 32'(dma_active), 32'd1);
    // Stray $4014 writes while halted must not disturb the transfer.
    for (int k = 0; k < 700 && done_cnt == 0; k++) strobe(16'h4014, 8'hA5, 1'b1, v.gap);
    if (done_cnt == 0) check("timeout", 32'd0, 32'd1);
    strobe(16'h0000, 8'h00, 1'b0, v.gap);
    check("halt_cycles", 32'(halted_cnt), 32'(exp_len));
    check("done_count", 32'(done_cnt), 32'd1);
    check("writes", 32'(wr_cnt), 32'd256);
    check("queue_left", 32'(exp_data.size()), 32'd0);
    check("first_rd", 32'(first_rd_seen), 32'(v.first_rd));
    check("last_rd", 32'(last_rd_seen), 32'(v.last_rd));
    check("idle_outputs", 32'({cpu_halt, dma_active, bus_rwe, bus_addr, bus_wdata}), 32'd0);
  endtask

  vec_t vecs[4];
  int   dummy_len;

  initial begin
    vecs[0] = '{page: 8'h02, gap: 2, pre: 0, first_rd: 16'h0200, last_rd: 16'h02FF};
    vecs[1] = '{page: 8'h02, gap: 2, pre: 1, first_rd: 16'h0200, last_rd: 16'h02FF};
    vecs[2] = '{page: 8'hFF, gap: 2, pre: 0, first_rd: 16'hFF00, last_rd: 16'hFFFF};
    vecs[3] = '{page: 8'h07, gap: 3, pre: 1, first_rd: 16'h0700, last_rd: 16'h07FF};

    reset = 1'b1; cpu_ce = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0; cpu_rwe = 1'b0;
    strobe_cnt = 0; last_addr = 16'h0; first_rd_seen = 16'h0; last_rd_seen = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({cpu_halt, dma_active, bus_rwe, done_pulse, bus_addr, bus_wdata}), 32'd0);
    reset = 1'b0;

    // Read of $4014 and write of $4015 must not start anything.
    halted_cnt = 0; done_cnt = 0; wr_cnt = 0;
    strobe(16'h4014, 8'h33, 1'b0, 2);
    strobe(16'h4015, 8'h33, 1'b1, 2);
    strobe(16'h0000, 8'h00, 1'b0, 2);
    check("no_trigger_halt", 32'(halted_cnt), 32'd0);
    check("no_trigger_outputs", 32'({cpu_halt, dma_active, bus_rwe, bus_addr}), 32'd0);

    for (int r = 0; r < 4; r++) run_row(vecs[r]);

    // Reset after 10 bytes aborts immediately; the next trigger starts from idx 0.
    start_dma(8'h02, 2, dummy_len);
    for (int k = 0; k < 100 && wr_cnt < 10; k++) strobe(16'h0000, 8'h00, 1'b0, 2);
    check("mid_writes", 32'(wr_cnt), 32'd10);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_halt", 32'(cpu_halt), 32'd0);
    check("reset_rwe", 32'(bus_rwe), 32'd0);
    check("reset_active", 32'(dma_active), 32'd0);
    reset = 1'b0;
    strobe_cnt = 0;
    run_row(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
